regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write 64-bit integer register file.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so decode can stall on pending writebacks.
- Sits between decode (read and reserve) and writeback (write and release) in the core pipeline.

Parameters:
XLEN, 64, register data width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = a read returns the same-cycle write data; 0 = a read returns the stored value only

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset; reset==0 at posedge clears all state
rd_idx  in  NRD x log2(NREGS)  read register indices
rd_val  out  NRD x XLEN  read data (combinational)
rd_busy  out  NRD  the indexed register has a pending write
stall  out  1  OR of rd_busy over ports whose rd_en=1
rd_en  in  NRD  read port is in use; qualifies stall only
rsv_en  in  1  reserve the destination register (instruction issued)
rsv_idx  in  log2(NREGS)  destination register to mark busy
wr_en  in  NWR  write strobe per port
wr_idx  in  NWR x log2(NREGS)  write destination per port
wr_val  in  NWR x XLEN  write data per port
wr_rel  in  NWR  clear the busy bit of wr_idx with this write

Behaviour:
Reset
- With reset==0 at posedge, all registers go to 0 and all busy bits go to 0.
- Reset takes priority over any concurrent write or reserve in that cycle.
- After reset, rd_val=0, rd_busy=0 and stall=0 for every index.

Register 0
- Reads of index 0 always return 0 with rd_busy=0.
- Writes and reserves to index 0 are ignored; register 0 and its busy bit never change.

Write
- When wr_en[p]=1 and wr_idx[p]!=0, reg[wr_idx[p]] takes wr_val[p] at the posedge.
- Write latency is 1 cycle: the stored value is visible to a non-bypassed read on the next cycle.
- If several ports write the same index, the highest port number wins, deterministically.

Read
- Combinational from rd_idx; zero-cycle latency.
- With BYPASS=1, if any enabled write port targets rd_idx (nonzero) this cycle, rd_val returns that port's wr_val, using the same highest-port-wins rule.
- With BYPASS=0, rd_val returns the stored value.

Scoreboard
- Busy bit is set at posedge by rsv_en=1 with rsv_idx!=0.
- Busy bit is cleared at posedge by wr_en[p]=1, wr_rel[p]=1 and wr_idx[p]==idx.
- Reserve and release of the same index in the same cycle leave the bit set (the new producer wins).
- Reserving an already-busy register keeps it busy; there is no counting. One outstanding producer per register is guaranteed by issue.
- A write with wr_rel=0 updates data only and does not change the busy bit.
- rd_busy[i] = busy[rd_idx[i]].
  - With BYPASS=1, rd_busy[i] is forced to 0 when a releasing write to that index occurs in the same cycle, since the data is forwarded.
  - With BYPASS=0, rd_busy[i] is not masked.
- stall = OR over i of (rd_en[i] & rd_busy[i]).

Widths
- Index width is log2(NREGS).
- Out-of-range indices cannot occur because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT and NREGS_DEFAULT
  - typedef reg_idx_t (logic [log2(NREGS)-1:0])
  - typedef xword_t (logic [XLEN-1:0])
  - ZERO_REG constant
- One sub-module, reg_scoreboard, owns the busy vector: set/clear/priority logic, reset, and rd_busy/stall generation.
- regfile_scoreboard holds the data array, the write-priority mux and the bypass mux.

Test Plan:
1. Reset behaviour: hold reset=0 for 2 cycles after random writes -> all rd_val=0, rd_busy=0, stall=0.
2. Write then read, and register 0: write x5=0xDEADBEEF_00000001 -> the next-cycle read of rd_idx=5 returns that value; write x0=0xFFFF -> rd_val for index 0 stays 0.
3. Bypass and write conflict:
   - BYPASS=1: wr_idx[0]=7 val=0x11 while rd_idx[0]=7 -> rd_val=0x11 in the same cycle.
   - BYPASS=0: the same stimulus returns the old value, then 0x11 on the next cycle.
   - Ports 0 and 1 both write x9 with 0xAA and 0xBB -> x9=0xBB.
4. Scoreboard stall: rsv x3 -> next cycle rd_idx=3 with rd_en=1 gives rd_busy=1 and stall=1; release write x3=0x42 -> stall=0 that cycle (BYPASS=1) and rd_val=0x42.
5. Simultaneous reserve and release: rsv_idx=4 together with a releasing write to x4 -> busy[4]=1 afterward and x4 holds the written data. Also assert reset mid-stall and confirm busy clears on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file with writeback scoreboard.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;
    localparam int IDX_W_DEFAULT = $clog2(NREGS_DEFAULT);

    typedef logic [IDX_W_DEFAULT-1:0] reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0]  xword_t;

    // Architectural zero register: hard-wired to 0 and never busy.
    localparam reg_idx_t ZERO_REG = '0;

    // True when an index names a writable register (anything but x0).
    function automatic logic is_live_idx(input logic [31:0] idx);
        return (idx != 32'(ZERO_REG));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: reserve at issue, release at writeback, stall generation for decode.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][IW-1:0]   rd_idx,
    input  logic [NRD-1:0]           rd_en,
    input  logic                     rsv_en,
    input  logic [IW-1:0]            rsv_idx,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][IW-1:0]   wr_idx,
    input  logic [NWR-1:0]           wr_rel,
    output logic [NRD-1:0]           rd_busy,
    output logic                     stall
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] rel_hit_s;

    // Registers being released by a writeback this cycle.
    always_comb begin
        rel_hit_s = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_rel[p]) begin
                rel_hit_s[wr_idx[p]] = 1'b1;
            end else begin
                rel_hit_s = rel_hit_s;
            end
        end
    end

    // Next busy vector: release first, then reserve so a new producer wins.
    always_comb begin
        busy_d = busy_q & ~rel_hit_s;
        if (rsv_en && is_live_idx(32'(rsv_idx))) begin
            busy_d[rsv_idx] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup; forwarded release data hides the busy bit when bypassing.
    always_comb begin
        rd_busy = '0;
        stall   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if ((BYPASS != 0) && rel_hit_s[rd_idx[i]]) begin
                rd_busy[i] = 1'b0;
            end else begin
                rd_busy[i] = busy_q[rd_idx[i]];
            end
            stall = stall | (rd_en[i] & rd_busy[i]);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported integer register file with optional write-to-read bypass and a busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][IW-1:0]   rd_idx,
    output logic [NRD-1:0][XLEN-1:0] rd_val,
    output logic [NRD-1:0]           rd_busy,
    output logic                     stall,
    input  logic [NRD-1:0]           rd_en,
    input  logic                     rsv_en,
    input  logic [IW-1:0]            rsv_idx,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][IW-1:0]   wr_idx,
    input  logic [NWR-1:0][XLEN-1:0] wr_val,
    input  logic [NWR-1:0]           wr_rel
);

    logic [NREGS-1:0][XLEN-1:0] mem_q;
    logic [NREGS-1:0][XLEN-1:0] mem_d;

    // Write merge: ports applied in ascending order so the highest port wins.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && is_live_idx(32'(wr_idx[p]))) begin
                mem_d[wr_idx[p]] = wr_val[p];
            end else begin
                mem_d = mem_d;
            end
        end
        mem_d[0] = '0;
    end

    // Data array register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read mux; x0 never matches a bypass so it always reads the zeroed entry.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_val[i] = mem_q[rd_idx[i]];
            for (int p = 0; p < NWR; p++) begin
                if ((BYPASS != 0) && wr_en[p] && (wr_idx[p] == rd_idx[i])
                    && is_live_idx(32'(rd_idx[i]))) begin
                    rd_val[i] = wr_val[p];
                end else begin
                    rd_val[i] = rd_val[i];
                end
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (rd_idx),
        .rd_en   (rd_en),
        .rsv_en  (rsv_en),
        .rsv_idx (rsv_idx),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_rel  (wr_rel),
        .rd_busy (rd_busy),
        .stall   (stall)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: bypassing and non-bypassing instances share stimulus; random phase vs. model, then directed table.
module tb_regfile_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int IW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic [NRD-1:0][IW-1:0]   rd_idx;
    logic [NRD-1:0]           rd_en;
    logic                     rsv_en;
    logic [IW-1:0]            rsv_idx;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][IW-1:0]   wr_idx;
    logic [NWR-1:0][XLEN-1:0] wr_val;
    logic [NWR-1:0]           wr_rel;

    logic [NRD-1:0][XLEN-1:0] rd_val_b1, rd_val_b0;
    logic [NRD-1:0]           rd_busy_b1, rd_busy_b0;
    logic                     stall_b1, stall_b0;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_val(rd_val_b1), .rd_busy(rd_busy_b1),
        .stall(stall_b1), .rd_en(rd_en), .rsv_en(rsv_en), .rsv_idx(rsv_idx), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_val(wr_val), .wr_rel(wr_rel)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_val(rd_val_b0), .rd_busy(rd_busy_b0),
        .stall(stall_b0), .rd_en(rd_en), .rsv_en(rsv_en), .rsv_idx(rsv_idx), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_val(wr_val), .wr_rel(wr_rel)
    );

    int checks = 0;
    int errors = 0;

    // Architectural state of the reference model.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Value a read of idx should observe right now.
    function automatic logic [XLEN-1:0] exp_val(input bit byp, input int idx);
        logic [XLEN-1:0] v;
        if (idx == 0) return '0;
        v = m_regs[idx];
        if (byp) begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && int'(wr_idx[p]) == idx) v = wr_val[p];
        end
        return v;
    endfunction

    function automatic bit exp_busy(input bit byp, input int idx);
        if (idx == 0) return 1'b0;
        if (byp) begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_rel[p] && int'(wr_idx[p]) == idx) return 1'b0;
        end
        return m_busy[idx];
    endfunction

    // Apply the architectural effect of the current inputs at a clock edge.
    task automatic model_clock();
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_idx[p] != 5'd0) m_regs[wr_idx[p]] = wr_val[p];
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_rel[p]) m_busy[wr_idx[p]] = 1'b0;
            if (rsv_en && rsv_idx != 5'd0) m_busy[rsv_idx] = 1'b1;
        end
    endtask

    task automatic check_model(input int cyc);
        bit s1, s0;
        s1 = 1'b0;
        s0 = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rnd%0d val_b1[%0d]", cyc, i), rd_val_b1[i], exp_val(1'b1, int'(rd_idx[i])));
            chk($sformatf("rnd%0d val_b0[%0d]", cyc, i), rd_val_b0[i], exp_val(1'b0, int'(rd_idx[i])));
            chk($sformatf("rnd%0d busy_b1[%0d]", cyc, i), 64'(rd_busy_b1[i]), 64'(exp_busy(1'b1, int'(rd_idx[i]))));
            chk($sformatf("rnd%0d busy_b0[%0d]", cyc, i), 64'(rd_busy_b0[i]), 64'(exp_busy(1'b0, int'(rd_idx[i]))));
            s1 = s1 | (rd_en[i] & exp_busy(1'b1, int'(rd_idx[i])));
            s0 = s0 | (rd_en[i] & exp_busy(1'b0, int'(rd_idx[i])));
        end
        chk($sformatf("rnd%0d stall_b1", cyc), 64'(stall_b1), 64'(s1));
        chk($sformatf("rnd%0d stall_b0", cyc), 64'(stall_b0), 64'(s0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    typedef struct {
        bit              rst_n;
        bit              rsv;
        logic [4:0]      rsv_i;
        logic [1:0]      we;
        logic [4:0]      wi0;
        logic [63:0]     wv0;
        logic [4:0]      wi1;
        logic [63:0]     wv1;
        logic [1:0]      rel;
        logic [4:0]      ri;
        bit              re;
        logic [63:0]     v1;
        logic [63:0]     v0;
        bit              b1;
        bit              b0;
        bit              s1;
        bit              s0;
    } vec_t;

    vec_t vq[$];

    initial begin
        // rst_n rsv rsv_i we wi0 wv0 wi1 wv1 rel ri re | v1 v0 b1 b0 s1 s0
        vq.push_back(vec_t'{1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd5, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b01, 5'd5, 64'hDEADBEEF_00000001, 5'd0, 64'h0, 2'b00, 5'd5, 1'b0, 64'hDEADBEEF_00000001, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b01, 5'd0, 64'hFFFF, 5'd0, 64'h0, 2'b00, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd5, 1'b0, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b01, 5'd7, 64'h11, 5'd0, 64'h0, 2'b00, 5'd7, 1'b0, 64'h11, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd7, 1'b0, 64'h11, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b11, 5'd9, 64'hAA, 5'd9, 64'hBB, 2'b00, 5'd9, 1'b0, 64'hBB, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd9, 1'b0, 64'hBB, 64'hBB, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b1, 5'd3, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd3, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd3, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b01, 5'd3, 64'h42, 5'd0, 64'h0, 2'b01, 5'd3, 1'b1, 64'h42, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd3, 1'b1, 64'h42, 64'h42, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b1, 5'd4, 2'b01, 5'd4, 64'h55, 5'd0, 64'h0, 2'b01, 5'd4, 1'b1, 64'h55, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd4, 1'b1, 64'h55, 64'h55, 1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b01, 5'd4, 64'h66, 5'd0, 64'h0, 2'b00, 5'd4, 1'b1, 64'h66, 64'h55, 1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd4, 1'b0, 64'h66, 64'h66, 1'b1, 1'b1, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd4, 1'b1, 64'h66, 64'h66, 1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd4, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 1'b1, 5'd6, 2'b01, 5'd6, 64'h77, 5'd0, 64'h0, 2'b00, 5'd6, 1'b1, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd6, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b1, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 5'd0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        reset   = 1'b0;
        rd_idx  = '0;
        rd_en   = '0;
        rsv_en  = 1'b0;
        rsv_idx = '0;
        wr_en   = '0;
        wr_idx  = '0;
        wr_val  = '0;
        wr_rel  = '0;
        @(negedge clk);
        tick();

        // Randomised phase: small index range to provoke port conflicts and scoreboard hazards.
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 59) != 0);
            rsv_en  = $urandom_range(0, 1);
            rsv_idx = 5'($urandom_range(0, 7));
            for (int p = 0; p < NWR; p++) begin
                wr_en[p]  = ($urandom_range(0, 2) != 0);
                wr_idx[p] = 5'($urandom_range(0, 7));
                wr_val[p] = {$urandom, $urandom};
                wr_rel[p] = $urandom_range(0, 1);
            end
            for (int i = 0; i < NRD; i++) begin
                rd_idx[i] = (c % 16 == 15) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
                rd_en[i]  = $urandom_range(0, 1);
            end
            #1;
            check_model(c);
            tick();
        end

        // Directed table, port 0 observed, port 1 idle.
        for (int k = 0; k < vq.size(); k++) begin
            reset     = vq[k].rst_n;
            rsv_en    = vq[k].rsv;
            rsv_idx   = vq[k].rsv_i;
            wr_en     = vq[k].we;
            wr_idx[0] = vq[k].wi0;
            wr_val[0] = vq[k].wv0;
            wr_idx[1] = vq[k].wi1;
            wr_val[1] = vq[k].wv1;
            wr_rel    = vq[k].rel;
            rd_idx[0] = vq[k].ri;
            rd_en[0]  = vq[k].re;
            rd_idx[1] = 5'd0;
            rd_en[1]  = 1'b0;
            #1;
            chk($sformatf("vec%0d val_b1", k), rd_val_b1[0], vq[k].v1);
            chk($sformatf("vec%0d val_b0", k), rd_val_b0[0], vq[k].v0);
            chk($sformatf("vec%0d busy_b1", k), 64'(rd_busy_b1[0]), 64'(vq[k].b1));
            chk($sformatf("vec%0d busy_b0", k), 64'(rd_busy_b0[0]), 64'(vq[k].b0));
            chk($sformatf("vec%0d stall_b1", k), 64'(stall_b1), 64'(vq[k].s1));
            chk($sformatf("vec%0d stall_b0", k), 64'(stall_b0), 64'(vq[k].s0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
